// File: rtl/array_sort_check_datapath_if.sv
// Bus between the array sort-check controller/host and the datapath stage.
// The master side writes the element store and issues the controller strobes.
// The slave side (the datapath) returns the scan status and the current index.
interface array_sort_check_datapath_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int IDXW  = 5
);
    // Element store write port
    logic             wr_en;
    logic [IDXW-1:0]  wr_addr;
    logic [WIDTH-1:0] wr_data;

    // Controller strobes
    logic [IDXW:0]    length_in;
    logic             load_input;
    logic             load_index;
    logic             select_index;

    // Status back to the controller
    logic             inversion_found;
    logic             end_of_array;
    logic             zero_length_array;
    logic [IDXW-1:0]  index_out;

    modport master (
        output wr_en, wr_addr, wr_data,
        output length_in, load_input, load_index, select_index,
        input  inversion_found, end_of_array, zero_length_array, index_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  length_in, load_input, load_index, select_index,
        output inversion_found, end_of_array, zero_length_array, index_out
    );
endinterface

// File: rtl/array_sort_check_datapath.sv
// Datapath stage for the array sort-check controller.
// Holds the element store, the latched array length and the scan index, and
// compares each element with its right-hand neighbour to report whether the
// array is still in non-decreasing (signed) order at the current position.
module array_sort_check_datapath #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int IDXW  = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    array_sort_check_datapath_if.slave    bus
);
    localparam logic [IDXW:0]   DEPTH_LEN = (IDXW+1)'(DEPTH);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(DEPTH - 1);

    // Element store contents survive reset; only the scan state is cleared.
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [IDXW:0]    len_reg;
    logic [IDXW-1:0]  index_reg;

    logic [IDXW-1:0]  index_inc;
    logic [IDXW:0]    index_ext;
    logic [WIDTH-1:0] elem_cur;
    logic [WIDTH-1:0] elem_nxt;
    logic             pair_in_range;

    // Element store write; honoured regardless of what the controller is doing.
    always_ff @(posedge clock) begin
        if (bus.wr_en) begin
            mem_reg[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Length and scan index; cleared asynchronously so a mid-scan reset takes
    // effect immediately. Length is clamped to the store size, and the index
    // saturates at the last entry instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_reg   <= '0;
            index_reg <= '0;
        end else begin
            if (bus.load_input) begin
                len_reg <= (bus.length_in > DEPTH_LEN) ? DEPTH_LEN : bus.length_in;
            end
            if (bus.load_index) begin
                if (!bus.select_index) begin
                    index_reg <= '0;
                end else if (index_reg != LAST_IDX) begin
                    index_reg <= index_inc;
                end
            end
        end
    end

    // Neighbour compare and status, purely from registered state so the
    // controller sees fresh status in the cycle after any strobe.
    // index_inc may wrap at the top entry, but pair_in_range masks that case
    // because len never exceeds DEPTH.
    always_comb begin
        index_inc     = index_reg + 1'b1;
        index_ext     = {1'b0, index_reg};
        elem_cur      = mem_reg[index_reg];
        elem_nxt      = mem_reg[index_inc];
        pair_in_range = (index_ext + (IDXW+1)'(1)) < len_reg;
    end

    assign bus.zero_length_array = (len_reg == '0);
    assign bus.end_of_array      = (len_reg != '0) && (index_ext >= (len_reg - (IDXW+1)'(1)));
    assign bus.inversion_found   = (len_reg >= (IDXW+1)'(2)) && pair_in_range &&
                                   ($signed(elem_cur) > $signed(elem_nxt));
    assign bus.index_out         = index_reg;

endmodule

// File: tb/tb_array_sort_check_datapath.sv
// Self-checking bench for array_sort_check_datapath: a table of directed
// vectors, hand-written multi-cycle sequences, and randomized traffic checked
// against an array-based reference model of the scan.
module tb_array_sort_check_datapath;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int IDXW  = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    array_sort_check_datapath_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW)) bus ();

    array_sort_check_datapath #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model: plain integers for the store, length and index.
    int mem_m [DEPTH];
    int len_m = 0;
    int idx_m = 0;

    typedef struct {
        bit we; int addr; int data; int lin; bit li; bit ld; bit sel;
        bit ez; bit ee; bit ei; int eidx;
    } vec_t;
    vec_t vecs [20];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_en        = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.length_in    = '0;
        bus.load_input   = 1'b0;
        bus.load_index   = 1'b0;
        bus.select_index = 1'b0;
    endtask

    // Apply one set of inputs across one rising edge and advance the model.
    task automatic drive(input bit we, input int addr, input int data, input int lin,
                         input bit li, input bit ld, input bit sel);
        bus.wr_en        = we;
        bus.wr_addr      = IDXW'(addr);
        bus.wr_data      = WIDTH'(data);
        bus.length_in    = (IDXW+1)'(lin);
        bus.load_input   = li;
        bus.load_index   = ld;
        bus.select_index = sel;
        @(posedge clock);
        if (we) mem_m[addr] = data;
        if (li) len_m = (lin > DEPTH) ? DEPTH : lin;
        if (ld) idx_m = sel ? ((idx_m + 1 > DEPTH - 1) ? DEPTH - 1 : idx_m + 1) : 0;
        #1;
        idle_inputs();
        txn++;
        $display("txn %0d: we=%0b a=%0d d=%0d lin=%0d li=%0b ld=%0b sel=%0b -> idx=%0d inv=%0b eoa=%0b zero=%0b",
                 txn, we, addr, data, lin, li, ld, sel, bus.index_out,
                 bus.inversion_found, bus.end_of_array, bus.zero_length_array);
    endtask

    // Compare all outputs against the model's view of the scan.
    task automatic check_model(input string tag);
        bit ez, ee, ei;
        ez = (len_m == 0);
        ee = (len_m != 0) && (idx_m >= len_m - 1);
        ei = 1'b0;
        if (idx_m + 1 < len_m) ei = (mem_m[idx_m] > mem_m[idx_m + 1]);
        chk({tag, " zero"}, int'(bus.zero_length_array), int'(ez));
        chk({tag, " eoa"},  int'(bus.end_of_array),      int'(ee));
        chk({tag, " inv"},  int'(bus.inversion_found),   int'(ei));
        chk({tag, " idx"},  int'(bus.index_out),         idx_m);
    endtask

    initial begin
        idle_inputs();
        // Directed table: sorted scan, inversion, signed pair, length boundaries.
        vecs[0]  = '{1, 0, -3, 0, 0, 0, 0,  1, 0, 0, 0};
        vecs[1]  = '{1, 1,  0, 0, 0, 0, 0,  1, 0, 0, 0};
        vecs[2]  = '{1, 2,  0, 0, 0, 0, 0,  1, 0, 0, 0};
        vecs[3]  = '{1, 3,  7, 0, 0, 0, 0,  1, 0, 0, 0};
        vecs[4]  = '{0, 0,  0, 4, 1, 1, 0,  0, 0, 0, 0};
        vecs[5]  = '{0, 0,  0, 0, 0, 1, 1,  0, 0, 0, 1};
        vecs[6]  = '{0, 0,  0, 0, 0, 1, 1,  0, 0, 0, 2};
        vecs[7]  = '{0, 0,  0, 0, 0, 1, 1,  0, 1, 0, 3};
        vecs[8]  = '{1, 0,  1, 0, 0, 0, 0,  0, 1, 0, 3};
        vecs[9]  = '{1, 1,  5, 0, 0, 0, 0,  0, 1, 0, 3};
        vecs[10] = '{1, 2,  2, 0, 0, 0, 0,  0, 1, 0, 3};
        vecs[11] = '{1, 3,  9, 0, 0, 0, 0,  0, 1, 0, 3};
        vecs[12] = '{0, 0,  0, 4, 1, 1, 0,  0, 0, 0, 0};
        vecs[13] = '{0, 0,  0, 0, 0, 1, 1,  0, 0, 1, 1};
        vecs[14] = '{1, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1};
        vecs[15] = '{1, 1, -1, 0, 0, 0, 0,  0, 0, 0, 1};
        vecs[16] = '{0, 0,  0, 2, 1, 1, 0,  0, 0, 1, 0};
        vecs[17] = '{0, 0,  0, 1, 1, 1, 0,  0, 1, 0, 0};
        vecs[18] = '{0, 0,  0, 0, 1, 0, 0,  1, 0, 0, 0};
        vecs[19] = '{0, 0,  0, 40, 1, 1, 0, 0, 0, 1, 0};

        // Known store contents so the model is defined everywhere.
        @(negedge clock);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, i, 100 + i, 0, 1'b0, 1'b0, 1'b0);

        // Reset pulse between edges: status must clear without a clock edge.
        drive(1'b0, 0, 0, 5, 1'b1, 1'b1, 1'b1);
        #2 reset = 1'b0;
        len_m = 0; idx_m = 0;
        #1;
        chk("reset zero", int'(bus.zero_length_array), 1);
        chk("reset eoa",  int'(bus.end_of_array),      0);
        chk("reset inv",  int'(bus.inversion_found),   0);
        chk("reset idx",  int'(bus.index_out),         0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        // Table-driven vectors.
        for (int v = 0; v < 20; v++) begin
            drive(vecs[v].we, vecs[v].addr, vecs[v].data, vecs[v].lin,
                  vecs[v].li, vecs[v].ld, vecs[v].sel);
            chk($sformatf("vec%0d zero", v), int'(bus.zero_length_array), int'(vecs[v].ez));
            chk($sformatf("vec%0d eoa", v),  int'(bus.end_of_array),      int'(vecs[v].ee));
            chk($sformatf("vec%0d inv", v),  int'(bus.inversion_found),   int'(vecs[v].ei));
            chk($sformatf("vec%0d idx", v),  int'(bus.index_out),         vecs[v].eidx);
        end

        // Index saturation at the last entry with len clamped to DEPTH.
        for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        chk("sat idx31", int'(bus.index_out), 31);
        chk("sat eoa31", int'(bus.end_of_array), 1);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        chk("sat hold idx", int'(bus.index_out), 31);
        check_model("sat");

        // Mid-scan write, then asynchronous reset at index 2.
        drive(1'b1, 0, 1, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1, 2, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2, 5, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3, 9, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 4, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        chk("mid idx2", int'(bus.index_out), 2);
        chk("mid inv before", int'(bus.inversion_found), 0);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = '0;
        #2;
        chk("mid inv pre-edge", int'(bus.inversion_found), 0);
        @(posedge clock);
        mem_m[3] = 0;
        #1;
        idle_inputs();
        chk("mid inv after write", int'(bus.inversion_found), 1);
        check_model("mid");
        #2 reset = 1'b0;
        len_m = 0; idx_m = 0;
        #1;
        chk("mid reset idx",  int'(bus.index_out),         0);
        chk("mid reset zero", int'(bus.zero_length_array), 1);
        chk("mid reset inv",  int'(bus.inversion_found),   0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        // Store survived reset: rescan {1,2,5,0}.
        drive(1'b0, 0, 0, 4, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        chk("retain inv", int'(bus.inversion_found), 1);
        check_model("retain");

        // Randomized traffic against the model.
        for (int r = 0; r < 400; r++) begin
            bit we, li, ld, sel;
            int addr, data, lin;
            we   = ($urandom_range(0, 2) == 0);
            addr = (idx_m + int'($urandom_range(0, 2))) % DEPTH;
            if ($urandom_range(0, 3) == 0) addr = int'($urandom_range(0, DEPTH - 1));
            data = int'($urandom_range(0, 8)) - 4;
            if ($urandom_range(0, 7) == 0) data = int'($urandom);
            lin  = int'($urandom_range(0, 40));
            li   = ($urandom_range(0, 15) == 0);
            ld   = ($urandom_range(0, 3) != 0);
            sel  = ($urandom_range(0, 11) != 0);
            drive(we, addr, data, lin, li, ld, sel);
            check_model($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
